// File: rtl/run_pause_ctrl.sv
// run_pause_ctrl: toggle-driven start/pause control for a 4-digit BCD tick counter (define RUN_PAUSE_SAT_EN to saturate at 9999 instead of wrapping)
module run_pause_ctrl #(
   parameter int TICK_DIV = 100000,
   parameter int PS_W     = 17
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        BTN_TOGGLE,
   input  logic        CLR,
   output logic        RUNNING,
   output logic [15:0] BCD_COUNT,
   output logic        WRAP,
   output logic        EVT
);
`ifdef RUN_PAUSE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   state_t state_q, state_d;
   logic sync1_q, sync2_q, prev_q, evt_q, wrap_q, run_q, wrap_d;
   logic [1:0] arm_q;
   logic [PS_W-1:0] ps_q, ps_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [4:0] cy;
   logic evt, tick, at_max;
   assign evt = (arm_q == 2'd3) && (sync2_q != prev_q);
   assign tick = (state_q == RUN) && (ps_q == PS_W'(TICK_DIV - 1));
   assign at_max = cy[4];
   assign RUNNING = run_q;
   assign BCD_COUNT = cnt_q;
   assign WRAP = wrap_q;
   assign EVT = evt_q;
   // BCD +1 with ripple carry between digits; carry out of the top digit flags 9999
   always_comb begin
      cnt_inc = cnt_q;
      cy = '0;
      cy[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cnt_inc[4*i +: 4] = cy[i] ? ((cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1) : cnt_q[4*i +: 4];
         cy[i+1] = cy[i] && (cnt_q[4*i +: 4] == 4'd9);
      end
   end
   // next state: clear wins, RUN advances prescaler and count, events flip run/pause
   always_comb begin
      state_d = state_q;
      ps_d = ps_q;
      cnt_d = cnt_q;
      wrap_d = 1'b0;
      if (CLR) begin
         state_d = IDLE;
         ps_d = '0;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         ps_d = tick ? '0 : ps_q + 1'b1;
         wrap_d = tick && at_max;
         cnt_d = tick ? ((SAT && at_max) ? cnt_q : cnt_inc) : cnt_q;
         state_d = (evt || (SAT && tick && at_max)) ? PAUSE : RUN;
      end else if (evt) begin
         state_d = RUN;
         ps_d = (state_q == IDLE) ? '0 : ps_q;
         cnt_d = (state_q == IDLE) ? '0 : cnt_q;
      end
   end
   // all state: input synchroniser, arming fill counter, FSM and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         arm_q   <= 2'd0;
         state_q <= IDLE;
         ps_q    <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         evt_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         sync1_q <= BTN_TOGGLE;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         arm_q   <= (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
         state_q <= state_d;
         ps_q    <= ps_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         evt_q   <= evt;
         run_q   <= (state_d == RUN);
      end
   end
endmodule

// File: tb/tb_run_pause_ctrl.sv
// tb_run_pause_ctrl: directed and random stimulus against a tick-counting reference model
module tb_run_pause_ctrl;
`ifdef RUN_PAUSE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam int TD = 4;
   logic CLK, RST_N, BTN_TOGGLE, CLR;
   logic RUNNING, WRAP, EVT;
   logic [15:0] BCD_COUNT;
   int errors = 0;
   int checks = 0;
   logic btn;
   bit m_run, m_act, m_wrap, m_evt;
   int m_ph, m_ticks, ne, wraps, t0, ph0;
   logic [15:0] frozen;
   logic samp[$];

   run_pause_ctrl #(.TICK_DIV(TD), .PS_W(3)) dut (
      .CLK(CLK), .RST_N(RST_N), .BTN_TOGGLE(BTN_TOGGLE), .CLR(CLR),
      .RUNNING(RUNNING), .BCD_COUNT(BCD_COUNT), .WRAP(WRAP), .EVT(EVT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] to_bcd(input int t);
      return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_act = 0; m_wrap = 0; m_evt = 0; m_ph = 0; m_ticks = 0; ne = 0;
      samp.delete();
      repeat (3) samp.push_back(1'b0);
   endtask

   // one clock edge of the reference: an event is a level change seen two samples late, once three edges have passed since reset
   task automatic model_edge(input logic b, input logic c);
      bit ev, tk;
      ne++;
      samp.push_back(b);
      if (samp.size() > 4) void'(samp.pop_front());
      ev = (ne >= 4) && (samp[1] != samp[0]);
      tk = m_run && (m_ph == TD - 1);
      m_evt = ev;
      m_wrap = 0;
      if (c) begin
         m_run = 0; m_act = 0; m_ph = 0; m_ticks = 0;
      end else if (m_run) begin
         m_ph = tk ? 0 : m_ph + 1;
         if (tk) begin
            if (m_ticks == 9999) begin
               m_wrap = 1;
               if (SAT) m_run = 0; else m_ticks = 0;
            end else m_ticks++;
         end
         if (ev) m_run = 0;
      end else if (ev) begin
         if (!m_act) begin m_ph = 0; m_ticks = 0; end
         m_act = 1; m_run = 1;
      end
   endtask

   task automatic cyc(input logic b, input logic c);
      BTN_TOGGLE = b; CLR = c;
      @(posedge CLK);
      model_edge(b, c);
      #1;
      chk("RUNNING", {15'd0, RUNNING}, {15'd0, m_run});
      chk("BCD_COUNT", BCD_COUNT, to_bcd(m_ticks));
      chk("WRAP", {15'd0, WRAP}, {15'd0, m_wrap});
      chk("EVT", {15'd0, EVT}, {15'd0, m_evt});
      if (WRAP) wraps++;
   endtask

   initial begin
      RST_N = 1'b0; BTN_TOGGLE = 1'b1; CLR = 1'b0; btn = 1'b1;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_running", {15'd0, RUNNING}, 16'd0);
      chk("rst_bcd", BCD_COUNT, 16'h0000);
      chk("rst_evt", {15'd0, EVT}, 16'd0);
      chk("rst_wrap", {15'd0, WRAP}, 16'd0);
      RST_N = 1'b1;
      // button high through reset release: no spurious event
      repeat (20) cyc(btn, 0);
      chk("armed_no_evt_bcd", BCD_COUNT, 16'h0000);
      // first press: event and RUNNING after the third edge, then 10 ticks in 40 cycles
      btn = ~btn;
      repeat (3) cyc(btn, 0);
      chk("start_evt", {15'd0, EVT}, 16'd1);
      chk("start_running", {15'd0, RUNNING}, 16'd1);
      repeat (40) cyc(btn, 0);
      chk("count_40", BCD_COUNT, 16'h0010);
      // pause mid-tick, hold, resume: the partial tick is kept
      for (int i = 0; i < 8 && m_ph != 2; i++) cyc(btn, 0);
      btn = ~btn;
      repeat (3) cyc(btn, 0);
      chk("pause_running", {15'd0, RUNNING}, 16'd0);
      frozen = BCD_COUNT;
      t0 = m_ticks;
      ph0 = m_ph;
      repeat (10) cyc(btn, 0);
      chk("pause_frozen", BCD_COUNT, frozen);
      btn = ~btn;
      repeat (3) cyc(btn, 0);
      chk("resume_running", {15'd0, RUNNING}, 16'd1);
      repeat (TD - 1 - ph0) cyc(btn, 0);
      chk("resume_no_tick_yet", BCD_COUNT, to_bcd(t0));
      cyc(btn, 0);
      chk("resume_first_tick", BCD_COUNT, to_bcd(t0 + 1));
      // run up to 9998, then cross the top of the range
      for (int i = 0; i < 50000 && m_ticks != 9998; i++) cyc(btn, 0);
      chk("preload_9998", BCD_COUNT, 16'h9998);
      for (int i = 0; i < TD - 1 && m_ph != 0; i++) cyc(btn, 0);
      wraps = 0;
      repeat (2 * TD) cyc(btn, 0);
      chk("wrap_once", 16'(wraps), 16'd1);
      chk("after_wrap_bcd", BCD_COUNT, SAT ? 16'h9999 : 16'h0000);
      chk("after_wrap_running", {15'd0, RUNNING}, SAT ? 16'd0 : 16'd1);
      repeat (2) cyc(btn, 0);
      // clear coinciding with an event while paused
      if (m_run) begin
         btn = ~btn;
         repeat (5) cyc(btn, 0);
      end
      btn = ~btn;
      repeat (2) cyc(btn, 0);
      cyc(btn, 1);
      chk("clr_evt", {15'd0, EVT}, 16'd1);
      chk("clr_running", {15'd0, RUNNING}, 16'd0);
      chk("clr_bcd", BCD_COUNT, 16'h0000);
      repeat (3) cyc(btn, 0);
      // async reset in the middle of counting
      btn = ~btn;
      for (int i = 0; i < 1000 && m_ticks != 123; i++) cyc(btn, 0);
      chk("pre_rst_bcd", BCD_COUNT, 16'h0123);
      #2 RST_N = 1'b0;
      #1;
      chk("async_rst_bcd", BCD_COUNT, 16'h0000);
      chk("async_rst_running", {15'd0, RUNNING}, 16'd0);
      chk("async_rst_evt", {15'd0, EVT}, 16'd0);
      chk("async_rst_wrap", {15'd0, WRAP}, 16'd0);
      model_reset();
      @(posedge CLK);
      #1 RST_N = 1'b1;
      // random presses and occasional clears
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0) btn = ~btn;
         cyc(btn, $urandom_range(0, 39) == 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
